vga_frame_buffer: RTL and testbench
===================================

Name: vga_frame_buffer

Overview:
- Parametrised, clocked successor to the combinational VGA buffer RAM. Provides a double-buffered (ping-pong) frame store between the masking pipeline (write side) and the VGA controller (read side).
- The pipeline fills the back bank while the controller reads the front bank.
- Banks swap only on a frame boundary, so the display never shows a partially written frame.
- Adds write handshake, registered read, bounds checking and a swap state machine.

Parameters:
- IMG_WIDTH, 320, pixels per row
- IMG_HEIGHT, 240, rows per frame
- PIXEL_W, 12, bits per pixel (RGB444)
- ROW_W, 8, row coordinate width; must satisfy 2^ROW_W >= IMG_HEIGHT
- COL_W, 9, column coordinate width; must satisfy 2^COL_W >= IMG_WIDTH
- BLANK_PIXEL, 12'h000, value returned for out-of-range reads

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write side may accept a pixel
- wr_row  in  ROW_W  write row
- wr_col  in  COL_W  write column
- wr_pixel  in  PIXEL_W  pixel data
- wr_frame_done  in  1  pulse: back-bank frame complete, request swap
- rd_frame_start  in  1  pulse from VGA controller at start of vertical blank
- rd_en  in  1  read request
- rd_row  in  ROW_W  read row
- rd_col  in  COL_W  read column
- rd_pixel  out  PIXEL_W  read data
- rd_valid  out  1  rd_pixel valid
- bank_sel  out  1  current front (read) bank; back bank is ~bank_sel
- frame_repeat  out  1  one-cycle pulse: rd_frame_start with no new frame ready
- oob_err  out  1  sticky: any out-of-range write or read since reset

Behaviour:
- Reset values (synchronous, active-high rst): bank_sel=0, state=WRITING, wr_ready=1, rd_pixel=0, rd_valid=0, frame_repeat=0, oob_err=0. Memory contents are not cleared.
- Storage: two banks of IMG_WIDTH*IMG_HEIGHT words of PIXEL_W bits. Address = row*IMG_WIDTH + col, computed at full width (ROW_W+COL_W bits); no truncation before the range check.
- Write: when wr_valid && wr_ready, the pixel is stored in the back bank at the rising edge. Latency 1 cycle; no write buffering.
- Out-of-range write (row >= IMG_HEIGHT or col >= IMG_WIDTH): write dropped and oob_err set.
- Read: when rd_en, rd_pixel/rd_valid are registered on the next edge (latency 1). rd_valid is deasserted the cycle after rd_en drops.
- Out-of-range read: returns BLANK_PIXEL with rd_valid=1 and sets oob_err.
- Read bank: uses the bank_sel value in effect in the request cycle (pre-swap).
- Reads and writes always target different banks, so there is no same-address collision.
- State machine:
  - WRITING: wr_ready=1.
    - wr_frame_done && !rd_frame_start -> SWAP_PENDING.
    - wr_frame_done && rd_frame_start -> toggle bank_sel; stay WRITING.
    - rd_frame_start alone -> frame_repeat pulse; no swap.
  - SWAP_PENDING: wr_ready=0 and writes are ignored.
    - rd_frame_start -> toggle bank_sel; -> WRITING. wr_ready=1 from the next cycle.
    - wr_frame_done here is ignored.
- A pixel accepted in the same cycle as wr_frame_done is written to the old back bank before the swap takes effect.
- Reset mid-frame abandons any pending swap; the partially written back bank is left in place.

Decomposition:
- Shared package / utils include: IMG_WIDTH, IMG_HEIGHT, PIXEL_W, ROW_W, COL_W defaults; state encoding WRITING=1'b0, SWAP_PENDING=1'b1; BLANK_PIXEL constant.
- One sub-module, vga_bank_ram: a single-bank synchronous RAM with one write port and one registered read port, instantiated twice.
- Top level holds bank_sel, the FSM, address/range logic and the output mux.

Test Plan:
- Reset then write (row 2, col 5, 12'hABC) with wr_ready=1; assert frame_done+frame_start together; read (2,5) -> next cycle rd_pixel=12'hABC, rd_valid=1, bank_sel=1.
- wr_frame_done at cycle 10, rd_frame_start at cycle 20 -> wr_ready=0 during cycles 11-20; write of 12'h111 at cycle 15 ignored; bank_sel toggles at 20; wr_ready=1 at 21.
- rd_frame_start with no frame_done -> frame_repeat=1 for one cycle; bank_sel unchanged; reads at (0,0) return the prior frame value.
- Write (240,0) and separately read (0,320) -> write dropped (back bank unchanged), read returns 12'h000, oob_err=1 and stays 1 until rst.
- Corner addresses: write 12'hF00 at (0,0) and 12'h00F at (239,319), swap, read both -> exact values, no aliasing.
- rst asserted while in SWAP_PENDING -> next cycle state=WRITING, wr_ready=1, bank_sel=0, rd_valid=0, oob_err=0.

Source files
------------

// File: rtl/vga_frame_buffer_pkg.sv
// Shared defaults, FSM state encoding and blank-pixel constant for the ping-pong frame buffer.
package vga_frame_buffer_pkg;

   localparam int unsigned DEF_IMG_WIDTH  = 320;
   localparam int unsigned DEF_IMG_HEIGHT = 240;
   localparam int unsigned DEF_PIXEL_W    = 12;
   localparam int unsigned DEF_ROW_W      = 8;
   localparam int unsigned DEF_COL_W      = 9;

   localparam logic [DEF_PIXEL_W-1:0] DEF_BLANK_PIXEL = 12'h000;

   typedef enum logic {
      StWriting     = 1'b0,
      StSwapPending = 1'b1
   } fb_state_e;

endpackage

// File: rtl/vga_frame_buffer_bank_ram.sv
// Single frame bank: one synchronous write port and one registered read port.
module vga_bank_ram #(
   parameter int unsigned DEPTH  = 76800,
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 12
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Only the output register is reset; the array contents survive reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_frame_buffer.sv
// Double-buffered frame store: the pipeline fills the back bank while the VGA controller reads the
// front bank; banks swap only when a finished frame meets a vertical-blank start.
module vga_frame_buffer
   import vga_frame_buffer_pkg::*;
#(
   parameter int unsigned         IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int unsigned         IMG_HEIGHT  = DEF_IMG_HEIGHT,
   parameter int unsigned         PIXEL_W     = DEF_PIXEL_W,
   parameter int unsigned         ROW_W       = DEF_ROW_W,
   parameter int unsigned         COL_W       = DEF_COL_W,
   parameter logic [PIXEL_W-1:0]  BLANK_PIXEL = DEF_BLANK_PIXEL
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wr_valid,
   output logic               o_wr_ready,
   input  logic [ROW_W-1:0]   i_wr_row,
   input  logic [COL_W-1:0]   i_wr_col,
   input  logic [PIXEL_W-1:0] i_wr_pixel,
   input  logic               i_wr_frame_done,
   input  logic               i_rd_frame_start,
   input  logic               i_rd_en,
   input  logic [ROW_W-1:0]   i_rd_row,
   input  logic [COL_W-1:0]   i_rd_col,
   output logic [PIXEL_W-1:0] o_rd_pixel,
   output logic               o_rd_valid,
   output logic               o_bank_sel,
   output logic               o_frame_repeat,
   output logic               o_oob_err
);

   localparam int unsigned ADDR_W = ROW_W + COL_W;
   localparam int unsigned DEPTH  = IMG_WIDTH * IMG_HEIGHT;

   fb_state_e r_state;
   logic      r_bank_sel, r_wr_ready, r_frame_repeat, r_oob_err;
   logic      r_rd_valid, r_rd_oob, r_rd_bank;

   logic [ADDR_W-1:0]  w_wr_addr, w_rd_addr;
   logic               w_wr_in_range, w_rd_in_range;
   logic               w_wr_accept, w_wr_en, w_rd_ram_en;
   logic [PIXEL_W-1:0] w_rdata0, w_rdata1;

   // Full-width address; range is checked on the coordinates so nothing aliases.
   assign w_wr_addr = ADDR_W'(i_wr_row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(i_wr_col);
   assign w_rd_addr = ADDR_W'(i_rd_row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(i_rd_col);

   assign w_wr_in_range = (32'(i_wr_row) < IMG_HEIGHT) && (32'(i_wr_col) < IMG_WIDTH);
   assign w_rd_in_range = (32'(i_rd_row) < IMG_HEIGHT) && (32'(i_rd_col) < IMG_WIDTH);

   assign w_wr_accept = i_wr_valid && r_wr_ready;
   assign w_wr_en     = w_wr_accept && w_wr_in_range;
   assign w_rd_ram_en = i_rd_en && w_rd_in_range;

   // Bank 0 is written while bank 1 is front, and vice versa.
   vga_bank_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (PIXEL_W)
   ) u_bank0 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_wr_en && r_bank_sel),
      .i_waddr (w_wr_addr),
      .i_wdata (i_wr_pixel),
      .i_re    (w_rd_ram_en && !r_bank_sel),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata0)
   );

   vga_bank_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (PIXEL_W)
   ) u_bank1 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_wr_en && !r_bank_sel),
      .i_waddr (w_wr_addr),
      .i_wdata (i_wr_pixel),
      .i_re    (w_rd_ram_en && r_bank_sel),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata1)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= StWriting;
         r_bank_sel     <= 1'b0;
         r_wr_ready     <= 1'b1;
         r_frame_repeat <= 1'b0;
      end else begin
         r_frame_repeat <= 1'b0;
         unique case (r_state)
            StWriting: begin
               if (i_wr_frame_done && i_rd_frame_start) begin
                  r_bank_sel <= ~r_bank_sel;
               end else if (i_wr_frame_done) begin
                  r_state    <= StSwapPending;
                  r_wr_ready <= 1'b0;
               end else if (i_rd_frame_start) begin
                  r_frame_repeat <= 1'b1;
               end
            end
            StSwapPending: begin
               if (i_rd_frame_start) begin
                  r_bank_sel <= ~r_bank_sel;
                  r_state    <= StWriting;
                  r_wr_ready <= 1'b1;
               end
            end
            default: r_state <= StWriting;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_valid <= 1'b0;
         r_rd_oob   <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_oob_err  <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            r_rd_oob  <= !w_rd_in_range;
            r_rd_bank <= r_bank_sel;
         end
         if ((w_wr_accept && !w_wr_in_range) || (i_rd_en && !w_rd_in_range)) begin
            r_oob_err <= 1'b1;
         end
      end
   end

   assign o_rd_pixel     = r_rd_oob ? BLANK_PIXEL : (r_rd_bank ? w_rdata1 : w_rdata0);
   assign o_rd_valid     = r_rd_valid;
   assign o_wr_ready     = r_wr_ready;
   assign o_bank_sel     = r_bank_sel;
   assign o_frame_repeat = r_frame_repeat;
   assign o_oob_err      = r_oob_err;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Self-checking bench for vga_frame_buffer: directed scenarios plus randomized traffic
// against a frame-level reference model.
module tb_vga_frame_buffer;

   localparam int W = 320;
   localparam int H = 240;

   logic        clk;
   logic        i_rst, i_wr_valid, i_wr_frame_done, i_rd_frame_start, i_rd_en;
   logic [7:0]  i_wr_row, i_rd_row;
   logic [8:0]  i_wr_col, i_rd_col;
   logic [11:0] i_wr_pixel;
   logic        o_wr_ready, o_rd_valid, o_bank_sel, o_frame_repeat, o_oob_err;
   logic [11:0] o_rd_pixel;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [11:0] mem_m [int];
   bit          m_bank, m_pending, m_ready, m_oob, m_rep;
   bit          exp_rd_valid, exp_known;
   logic [11:0] exp_rd_pixel;

   vga_frame_buffer u_dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_wr_valid       (i_wr_valid),
      .o_wr_ready       (o_wr_ready),
      .i_wr_row         (i_wr_row),
      .i_wr_col         (i_wr_col),
      .i_wr_pixel       (i_wr_pixel),
      .i_wr_frame_done  (i_wr_frame_done),
      .i_rd_frame_start (i_rd_frame_start),
      .i_rd_en          (i_rd_en),
      .i_rd_row         (i_rd_row),
      .i_rd_col         (i_rd_col),
      .o_rd_pixel       (o_rd_pixel),
      .o_rd_valid       (o_rd_valid),
      .o_bank_sel       (o_bank_sel),
      .o_frame_repeat   (o_frame_repeat),
      .o_oob_err        (o_oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit coord_oob(input int row, input int col);
      return (row >= H) || (col >= W);
   endfunction

   // Frame-level behaviour: front/back banks, a pending swap, and a sticky error.
   task automatic model_step();
      int key;
      if (i_rst) begin
         m_bank = 0; m_pending = 0; m_ready = 1; m_oob = 0; m_rep = 0;
         exp_rd_valid = 0; exp_rd_pixel = '0; exp_known = 1;
         return;
      end
      exp_rd_valid = i_rd_en;
      if (i_rd_en) begin
         if (coord_oob(int'(i_rd_row), int'(i_rd_col))) begin
            exp_rd_pixel = 12'h000; exp_known = 1; m_oob = 1;
         end else begin
            key = int'(m_bank) * 100000 + int'(i_rd_row) * W + int'(i_rd_col);
            exp_known = mem_m.exists(key);
            if (exp_known) exp_rd_pixel = mem_m[key];
         end
      end
      if (i_wr_valid && m_ready) begin
         if (coord_oob(int'(i_wr_row), int'(i_wr_col))) m_oob = 1;
         else mem_m[int'(!m_bank) * 100000 + int'(i_wr_row) * W + int'(i_wr_col)] = i_wr_pixel;
      end
      m_rep = 0;
      if (!m_pending) begin
         if (i_wr_frame_done && i_rd_frame_start) m_bank = !m_bank;
         else if (i_wr_frame_done) begin m_pending = 1; m_ready = 0; end
         else if (i_rd_frame_start) m_rep = 1;
      end else if (i_rd_frame_start) begin
         m_bank = !m_bank; m_pending = 0; m_ready = 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_rst = 0; i_wr_valid = 0; i_wr_frame_done = 0; i_rd_frame_start = 0; i_rd_en = 0;
      i_wr_row = '0; i_wr_col = '0; i_wr_pixel = '0; i_rd_row = '0; i_rd_col = '0;
   endtask

   task automatic set_wr(input int row, input int col, input logic [11:0] pix);
      i_wr_valid = 1; i_wr_row = 8'(row); i_wr_col = 9'(col); i_wr_pixel = pix;
   endtask

   task automatic set_rd(input int row, input int col);
      i_rd_en = 1; i_rd_row = 8'(row); i_rd_col = 9'(col);
   endtask

   task automatic test_reset();
      idle(); i_rst = 1; tick(); idle();
      n_checks += 6;
      if (o_bank_sel !== 1'b0) begin n_errors++; $display("FAIL reset_bank_sel: got %b want 0", o_bank_sel); end
      if (o_wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_wr_ready: got %b want 1", o_wr_ready); end
      if (o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", o_rd_valid); end
      if (o_rd_pixel !== 12'h000) begin n_errors++; $display("FAIL reset_rd_pixel: got %h want 000", o_rd_pixel); end
      if (o_frame_repeat !== 1'b0) begin n_errors++; $display("FAIL reset_repeat: got %b want 0", o_frame_repeat); end
      if (o_oob_err !== 1'b0) begin n_errors++; $display("FAIL reset_oob: got %b want 0", o_oob_err); end
   endtask

   task automatic test_basic_swap();
      idle(); set_wr(2, 5, 12'hABC); tick();
      idle(); i_wr_frame_done = 1; i_rd_frame_start = 1; tick();
      n_checks++;
      if (o_bank_sel !== 1'b1) begin n_errors++; $display("FAIL basic_bank_sel: got %b want 1", o_bank_sel); end
      idle(); set_rd(2, 5); tick();
      n_checks += 2;
      if (o_rd_pixel !== 12'hABC) begin n_errors++; $display("FAIL basic_rd_pixel: got %h want abc", o_rd_pixel); end
      if (o_rd_valid !== 1'b1) begin n_errors++; $display("FAIL basic_rd_valid: got %b want 1", o_rd_valid); end
      idle(); tick();
      n_checks++;
      if (o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL basic_rd_valid_drop: got %b want 0", o_rd_valid); end
   endtask

   task automatic test_swap_pending();
      int bad_ready = 0;
      idle(); set_wr(3, 3, 12'h222); tick();
      idle(); i_wr_frame_done = 1; tick();
      for (int c = 11; c < 20; c++) begin
         idle();
         if (c == 15) set_wr(3, 3, 12'h111);
         if (c == 16) i_wr_frame_done = 1;
         tick();
         if (o_wr_ready !== 1'b0 || o_bank_sel !== 1'b1) bad_ready++;
      end
      n_checks++;
      if (bad_ready != 0) begin n_errors++; $display("FAIL pending_hold: %0d cycles wrong, want 0", bad_ready); end
      idle(); i_rd_frame_start = 1; tick();
      n_checks += 2;
      if (o_bank_sel !== 1'b0) begin n_errors++; $display("FAIL pending_bank_sel: got %b want 0", o_bank_sel); end
      if (o_wr_ready !== 1'b1) begin n_errors++; $display("FAIL pending_wr_ready: got %b want 1", o_wr_ready); end
      idle(); set_rd(3, 3); tick();
      n_checks++;
      if (o_rd_pixel !== 12'h222) begin n_errors++; $display("FAIL pending_ignored_write: got %h want 222", o_rd_pixel); end
   endtask

   task automatic test_frame_repeat();
      idle(); i_rd_frame_start = 1; tick();
      n_checks += 2;
      if (o_frame_repeat !== 1'b1) begin n_errors++; $display("FAIL repeat_pulse: got %b want 1", o_frame_repeat); end
      if (o_bank_sel !== 1'b0) begin n_errors++; $display("FAIL repeat_bank_sel: got %b want 0", o_bank_sel); end
      idle(); set_rd(3, 3); tick();
      n_checks += 2;
      if (o_frame_repeat !== 1'b0) begin n_errors++; $display("FAIL repeat_one_cycle: got %b want 0", o_frame_repeat); end
      if (o_rd_pixel !== 12'h222) begin n_errors++; $display("FAIL repeat_prior_frame: got %h want 222", o_rd_pixel); end
   endtask

   task automatic test_oob();
      idle(); set_wr(2, 0, 12'h3C3); tick();
      idle(); set_wr(1, 320, 12'h5A5); tick();
      n_checks++;
      if (o_oob_err !== 1'b1) begin n_errors++; $display("FAIL oob_write_flag: got %b want 1", o_oob_err); end
      idle(); set_wr(240, 0, 12'h777); tick();
      idle(); set_rd(0, 320); tick();
      n_checks += 2;
      if (o_rd_pixel !== 12'h000) begin n_errors++; $display("FAIL oob_read_blank: got %h want 000", o_rd_pixel); end
      if (o_rd_valid !== 1'b1) begin n_errors++; $display("FAIL oob_read_valid: got %b want 1", o_rd_valid); end
      idle(); i_wr_frame_done = 1; i_rd_frame_start = 1; tick();
      idle(); set_rd(2, 0); tick();
      n_checks++;
      if (o_rd_pixel !== 12'h3C3) begin n_errors++; $display("FAIL oob_no_alias: got %h want 3c3", o_rd_pixel); end
      idle();
      repeat (5) tick();
      n_checks++;
      if (o_oob_err !== 1'b1) begin n_errors++; $display("FAIL oob_sticky: got %b want 1", o_oob_err); end
   endtask

   task automatic test_corners();
      idle(); set_wr(0, 0, 12'hF00); tick();
      idle(); set_wr(239, 319, 12'h00F); tick();
      idle(); i_wr_frame_done = 1; i_rd_frame_start = 1; tick();
      idle(); set_rd(0, 0); tick();
      n_checks++;
      if (o_rd_pixel !== 12'hF00) begin n_errors++; $display("FAIL corner_first: got %h want f00", o_rd_pixel); end
      idle(); set_rd(239, 319); tick();
      n_checks++;
      if (o_rd_pixel !== 12'h00F) begin n_errors++; $display("FAIL corner_last: got %h want 00f", o_rd_pixel); end
   endtask

   task automatic test_reset_pending();
      idle(); i_wr_frame_done = 1; tick();
      n_checks++;
      if (o_wr_ready !== 1'b0) begin n_errors++; $display("FAIL rstp_enter_pending: got %b want 0", o_wr_ready); end
      idle(); set_rd(0, 0); i_rst = 1; tick();
      idle();
      n_checks += 4;
      if (o_wr_ready !== 1'b1) begin n_errors++; $display("FAIL rstp_wr_ready: got %b want 1", o_wr_ready); end
      if (o_bank_sel !== 1'b0) begin n_errors++; $display("FAIL rstp_bank_sel: got %b want 0", o_bank_sel); end
      if (o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL rstp_rd_valid: got %b want 0", o_rd_valid); end
      if (o_oob_err !== 1'b0) begin n_errors++; $display("FAIL rstp_oob: got %b want 0", o_oob_err); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         idle();
         i_rst = ($urandom_range(0, 99) == 0);
         i_wr_valid = $urandom_range(0, 1);
         i_wr_row = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(236, 255)) : 8'($urandom_range(0, 3));
         i_wr_col = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(316, 511)) : 9'($urandom_range(0, 3));
         i_wr_pixel = 12'($urandom);
         i_rd_en = $urandom_range(0, 1);
         i_rd_row = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(236, 255)) : 8'($urandom_range(0, 3));
         i_rd_col = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(316, 511)) : 9'($urandom_range(0, 3));
         i_wr_frame_done = ($urandom_range(0, 19) == 0);
         i_rd_frame_start = ($urandom_range(0, 14) == 0);
         tick();
         n_checks += 5;
         if (o_bank_sel !== m_bank) begin n_errors++; $display("FAIL rnd_bank_sel[%0d]: got %b want %b", n, o_bank_sel, m_bank); end
         if (o_wr_ready !== m_ready) begin n_errors++; $display("FAIL rnd_wr_ready[%0d]: got %b want %b", n, o_wr_ready, m_ready); end
         if (o_frame_repeat !== m_rep) begin n_errors++; $display("FAIL rnd_repeat[%0d]: got %b want %b", n, o_frame_repeat, m_rep); end
         if (o_oob_err !== m_oob) begin n_errors++; $display("FAIL rnd_oob[%0d]: got %b want %b", n, o_oob_err, m_oob); end
         if (o_rd_valid !== exp_rd_valid) begin n_errors++; $display("FAIL rnd_rd_valid[%0d]: got %b want %b", n, o_rd_valid, exp_rd_valid); end
         if (exp_rd_valid && exp_known) begin
            n_checks++;
            if (o_rd_pixel !== exp_rd_pixel) begin
               n_errors++; $display("FAIL rnd_rd_pixel[%0d]: got %h want %h", n, o_rd_pixel, exp_rd_pixel);
            end
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_basic_swap();
      test_swap_pending();
      test_frame_repeat();
      test_oob();
      test_corners();
      test_reset_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
